uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART_TX serializer between N byte requesters.
- Captures the granted requester's byte and issues a one-cycle tx_start with tx_din.
- Waits for the serializer's tx_done_tick, then enforces an inter-frame gap before the next grant.
- Sits between on-chip byte producers (debug, status, RISC-V core MMIO) and UART_TX. Includes a watchdog for a stalled serializer.

---
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART_TX serializer between N byte requesters. Requesters are
//   chosen round-robin. The chosen byte is captured and launched with a
//   one-cycle tx_start. The arbiter then waits for tx_done_tick, which a
//   watchdog bounds, and holds off for GAP_CYCLES before it grants again.
//
// Ports
//   clk           in   rising-edge system clock
//   reset_n       in   asynchronous active-low reset
//   req           in   [N]       per-requester request level
//   req_data      in   [N*DBIT]  packed bytes, requester i at [i*DBIT +: DBIT]
//   ack           out  [N]       one-hot pulse: requester byte captured
//   done          out  [N]       one-hot pulse: requester byte transmitted
//   tx_start      out            one-cycle start pulse to UART_TX
//   tx_din        out  [DBIT]    byte to UART_TX, held until the next grant
//   tx_done_tick  in             completion pulse from UART_TX
//   busy          out            high in every state except IDLE
//   owner         out  [OW]      current / last granted requester
//   timeout_err   out            pulse when the watchdog aborts a frame
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int DBIT       = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 2000000,
  localparam int OW        = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      req,
  input  logic [N*DBIT-1:0] req_data,
  output logic [N-1:0]      ack,
  output logic [N-1:0]      done,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic [OW-1:0]     owner,
  output logic              timeout_err
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [N-1:0]    done_q, done_d;
  logic            tx_start_q, tx_start_d;
  logic            timeout_err_q, timeout_err_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [WW-1:0]   wd_q, wd_d;

  logic            grant_vld;
  logic [OW-1:0]   grant_idx;
  logic [OW-1:0]   nxt_ptr;

  // Cyclic first-set search starting at rr_ptr. The loop walks from the far
  // end back towards rr_ptr so the last hit written is the nearest one.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int unsigned idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = OW'(idx);
      end
    end
  end

  assign nxt_ptr = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    tx_din_d      = tx_din_q;
    ack_d         = '0;
    done_d        = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    gap_d         = gap_q;
    wd_d          = wd_q;

    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        wd_d  = '0;
        if (grant_vld) begin
          owner_d          = grant_idx;
          tx_din_d         = req_data[grant_idx*DBIT +: DBIT];
          ack_d[grant_idx] = 1'b1;
          tx_start_d       = 1'b1;
          state_d          = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (tx_done_tick || (wd_q == WW'(TIMEOUT - 1))) begin
          done_d[owner_q] = tx_done_tick;
          timeout_err_d   = ~tx_done_tick;
          rr_ptr_d        = nxt_ptr;
          wd_d            = '0;
          gap_d           = '0;
          state_d         = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      tx_din_q      <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      gap_q         <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      tx_din_q      <= tx_din_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      gap_q         <= gap_d;
      wd_q          <= wd_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign tx_start    = tx_start_q;
  assign tx_din      = tx_din_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: N=4, DBIT=8, GAP_CYCLES=16, TIMEOUT=50.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_done_tick;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_err;

  int n_vec = 0;
  int n_mis = 0;
  int rr_m  = 0;   // reference round-robin pointer

  uart_tx_arbiter #(
    .N(N), .DBIT(8), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done_tick(tx_done_tick), .busy(busy), .owner(owner),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requesting index found cyclically from pointer p.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // {ack, done, tx_start, timeout_err, busy, tx_din}
  function automatic logic [31:0] quiet(input logic bz, input logic [7:0] b);
    return 32'({4'b0, 4'b0, 1'b0, 1'b0, bz, b});
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({ack, done, tx_start, timeout_err, busy, tx_din});
  endfunction

  // Present a request pattern in IDLE; check the grant one edge later.
  task automatic start(input logic [3:0] reqv, input logic [31:0] data,
                       output int sel, output logic [7:0] b);
    sel = pick(reqv, rr_m);
    req = reqv;
    req_data = data;
    step();
    b = data[sel*8 +: 8];
    chk("grant_ack", 32'(ack), 32'(1) << sel);
    chk("grant_start", 32'(tx_start), 32'd1);
    chk("grant_owner", 32'(owner), 32'(sel));
    chk("grant_din", 32'(tx_din), 32'(b));
    chk("grant_busy", 32'(busy), 32'd1);
  endtask

  // Finish a frame: tick after d quiet cycles, or let the watchdog expire.
  // Then walk the gap with noise on req and expect IDLE exactly at the end.
  task automatic finish(input int sel, input logic [7:0] b, input int d, input bit tick);
    int nwait;
    nwait = tick ? d : TMO - 1;
    for (int k = 0; k < nwait; k++) begin
      step();
      chk("wait_quiet", obs_vec(), quiet(1'b1, b));
    end
    tx_done_tick = tick;
    step();
    tx_done_tick = 1'b0;
    chk("end_done", 32'(done), tick ? (32'(1) << sel) : 32'd0);
    chk("end_timeout", 32'(timeout_err), tick ? 32'd0 : 32'd1);
    chk("end_busy", 32'(busy), 32'd1);
    rr_m = (sel + 1) % N;
    for (int k = 0; k < GAP - 1; k++) begin
      req = 4'($urandom_range(1, 15));
      step();
      chk("gap_quiet", obs_vec(), quiet(1'b1, b));
    end
    step();
    chk("gap_exit_idle", obs_vec(), quiet(1'b0, b));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int sel;
    logic [7:0] b;

    reset_n = 1'b0;
    req = 4'b1111;
    req_data = 32'h4332_2110;
    tx_done_tick = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 32'({ack, done, tx_start, timeout_err, busy, owner, tx_din}), 32'd0);
    reset_n = 1'b1;

    // Fairness with all four held high: 0,1,2,3
    for (int f = 0; f < 4; f++) begin
      start(4'b1111, 32'h4332_2110, sel, b);
      chk("fair_order", 32'(owner), 32'(f));
      finish(sel, b, 3 + f * 7, 1'b1);
    end

    // Wrap-around after requester 3: 0 wins over 3
    start(4'b1001, 32'h5500_0066, sel, b);
    finish(sel, b, 8, 1'b1);

    // Single request with byte AA
    start(4'b0100, 32'h00AA_0000, sel, b);
    finish(sel, b, 20, 1'b1);

    // Watchdog expiry, then the next requester is served
    start(4'b0010, 32'h0000_5A00, sel, b);
    finish(sel, b, 0, 1'b0);
    start(4'b0110, 32'h0077_3C00, sel, b);
    finish(sel, b, 0, 1'b1);

    // Completion and watchdog in the same cycle: completion wins
    start(4'b1000, 32'hC300_0000, sel, b);
    finish(sel, b, TMO - 1, 1'b1);

    // tx_done_tick while IDLE is ignored
    req = 4'b0000;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("idle_tick_done", 32'(done), 32'd0);
    chk("idle_tick_busy", 32'(busy), 32'd0);
    step();
    chk("idle_tick_after", obs_vec(), quiet(1'b0, b));

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      logic [3:0]  rv;
      logic [31:0] dv;
      int          dl;
      bit          tk;
      rv = 4'($urandom_range(1, 15));
      dv = $urandom;
      dl = $urandom_range(0, 45);
      tk = ($urandom_range(0, 7) != 0);
      start(rv, dv, sel, b);
      finish(sel, b, dl, tk);
    end

    // Mid-frame reset: pointer is moved off 0 first
    start(4'b0001, 32'h0000_0011, sel, b);
    finish(sel, b, 2, 1'b1);
    start(4'b0100, 32'h00EE_0000, sel, b);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_regs", 32'({owner, tx_din, ack, tx_start}), 32'd0);
    rr_m = 0;
    step();
    reset_n = 1'b1;
    start(4'b1111, 32'h4433_2211, sel, b);
    chk("midrst_regrant", 32'(owner), 32'd0);
    finish(sel, b, 5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
